// File: rtl/intersection_ctrl.sv
// ----------------------------------------------------------------------------
// intersection_ctrl
//
// Sequencer for a two-way (NS / EW) intersection. Cycles green -> yellow ->
// all-red between the two directions, never lets both heads be non-red, and
// serves latched pedestrian requests with a walk phase inserted at an all-red.
// A pending request shortens the running green once its minimum time is met.
// Lamp outputs are a Moore decode of the state register.
//
// Optional feature (compile-time macro NIGHT_FLASH_EN):
//   When defined, night_mode diverts the all-red exit into a FLASH state in
//   which NS yellow and EW red blink with a half-period of T_FLASH cycles.
//   When undefined, night_mode is ignored and FLASH is unreachable.
//
// Ports:
//   clk          clock
//   rstn         asynchronous active-low reset
//   ped_req      pedestrian button, any high cycle registers a request
//   night_mode   night flash request (only with NIGHT_FLASH_EN)
//   ns_red/ns_yellow/ns_green   NS head lamp enables
//   ew_red/ew_yellow/ew_green   EW head lamp enables
//   walk         pedestrian walk lamp
//   ped_pending  registered pedestrian request outstanding
// ----------------------------------------------------------------------------
module intersection_ctrl #(
    parameter int CW          = 8,
    parameter int T_GREEN_NS  = 20,
    parameter int T_GREEN_EW  = 20,
    parameter int T_YELLOW    = 4,
    parameter int T_RED       = 2,
    parameter int T_WALK      = 10,
    parameter int T_MIN_GREEN = 8,
    parameter int T_FLASH     = 5
) (
    input  logic clk,
    input  logic rstn,
    input  logic ped_req,
    input  logic night_mode,
    output logic ns_red,
    output logic ns_yellow,
    output logic ns_green,
    output logic ew_red,
    output logic ew_yellow,
    output logic ew_green,
    output logic walk,
    output logic ped_pending
);

    typedef enum logic [2:0] {
        NS_G  = 3'd0,
        NS_Y  = 3'd1,
        RED_A = 3'd2,
        EW_G  = 3'd3,
        EW_Y  = 3'd4,
        RED_B = 3'd5,
        WALK  = 3'd6,
        FLASH = 3'd7
    } state_t;

    // Terminal counts: a state of duration T holds cnt = 0 .. T-1.
    localparam logic [CW-1:0] LAST_G_NS = CW'(T_GREEN_NS - 1);
    localparam logic [CW-1:0] LAST_G_EW = CW'(T_GREEN_EW - 1);
    localparam logic [CW-1:0] LAST_Y    = CW'(T_YELLOW - 1);
    localparam logic [CW-1:0] LAST_RED  = CW'(T_RED - 1);
    localparam logic [CW-1:0] LAST_WALK = CW'(T_WALK - 1);
    localparam logic [CW-1:0] LAST_MIN  = CW'(T_MIN_GREEN - 1);

    state_t        state, state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_last;
    logic          next_dir, next_dir_nxt;
    logic          enter_walk;

`ifdef NIGHT_FLASH_EN
    localparam logic [CW-1:0] LAST_FLASH = CW'(T_FLASH - 1);
    logic flash_on;
`else
    // night_mode and T_FLASH only matter when the flash feature is built.
    logic unused_flash_cfg;
    assign unused_flash_cfg = night_mode ^ (T_FLASH == 0);
`endif

    assign enter_walk = (state_nxt == WALK) && (state != WALK);

    // ------------------------------------------------------------------
    // State register, dwell counter, direction memory, request latch.
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples the pre-edge values, independent of statement order.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= RED_B;
            cnt         <= '0;
            next_dir    <= 1'b0;
            ped_pending <= 1'b0;
        end else begin
            state    <= state_nxt;
            next_dir <= next_dir_nxt;
            // cnt restarts on every state change and on a FLASH half-period wrap.
            cnt      <= ((state_nxt != state) || (cnt == cnt_last)) ? '0 : cnt + 1'b1;
            // Entering WALK absorbs any request arriving on that same edge.
            if (enter_walk)
                ped_pending <= 1'b0;
            else if (ped_req)
                ped_pending <= 1'b1;
        end
    end

`ifdef NIGHT_FLASH_EN
    // Blink phase: forced on at FLASH entry, toggles at each half-period wrap.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            flash_on <= 1'b0;
        else if ((state_nxt == FLASH) && (state != FLASH))
            flash_on <= 1'b1;
        else if ((state == FLASH) && (cnt == LAST_FLASH))
            flash_on <= ~flash_on;
    end
`endif

    // ------------------------------------------------------------------
    // Next-state logic.
    // NOTE: every output of this block gets a default first, so no path
    // through the case can leave a value unassigned and infer a latch.
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt    = state;
        next_dir_nxt = next_dir;
        cnt_last     = LAST_RED;
        case (state)
            NS_G: begin
                cnt_last = LAST_G_NS;
                if ((cnt == LAST_G_NS) || (ped_pending && (cnt >= LAST_MIN)))
                    state_nxt = NS_Y;
            end
            NS_Y: begin
                cnt_last = LAST_Y;
                if (cnt == LAST_Y) begin
                    state_nxt    = RED_A;
                    next_dir_nxt = 1'b1;
                end
            end
            EW_G: begin
                cnt_last = LAST_G_EW;
                if ((cnt == LAST_G_EW) || (ped_pending && (cnt >= LAST_MIN)))
                    state_nxt = EW_Y;
            end
            EW_Y: begin
                cnt_last = LAST_Y;
                if (cnt == LAST_Y) begin
                    state_nxt    = RED_B;
                    next_dir_nxt = 1'b0;
                end
            end
            RED_A, RED_B: begin
                cnt_last = LAST_RED;
                if (cnt == LAST_RED) begin
                    if (ped_pending)
                        state_nxt = WALK;
                    else
                        state_nxt = (state == RED_A) ? EW_G : NS_G;
`ifdef NIGHT_FLASH_EN
                    if (night_mode)
                        state_nxt = FLASH;
`endif
                end
            end
            WALK: begin
                cnt_last = LAST_WALK;
                if (cnt == LAST_WALK)
                    state_nxt = next_dir ? EW_G : NS_G;
            end
            FLASH: begin
`ifdef NIGHT_FLASH_EN
                cnt_last = LAST_FLASH;
                // Leave only at the wrap that would turn the lamps back on.
                if ((cnt == LAST_FLASH) && !flash_on && !night_mode) begin
                    state_nxt    = RED_B;
                    next_dir_nxt = 1'b0;
                end
`else
                state_nxt = RED_B;
`endif
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Lamp decode (Moore).
    // ------------------------------------------------------------------
    always_comb begin
        ns_red    = 1'b0;
        ns_yellow = 1'b0;
        ns_green  = 1'b0;
        ew_red    = 1'b0;
        ew_yellow = 1'b0;
        ew_green  = 1'b0;
        walk      = 1'b0;
        case (state)
            NS_G: begin
                ns_green = 1'b1;
                ew_red   = 1'b1;
            end
            NS_Y: begin
                ns_yellow = 1'b1;
                ew_red    = 1'b1;
            end
            EW_G: begin
                ew_green = 1'b1;
                ns_red   = 1'b1;
            end
            EW_Y: begin
                ew_yellow = 1'b1;
                ns_red    = 1'b1;
            end
            RED_A, RED_B: begin
                ns_red = 1'b1;
                ew_red = 1'b1;
            end
            WALK: begin
                ns_red = 1'b1;
                ew_red = 1'b1;
                walk   = 1'b1;
            end
            FLASH: begin
`ifdef NIGHT_FLASH_EN
                ns_yellow = flash_on;
                ew_red    = flash_on;
`else
                ns_red = 1'b1;
                ew_red = 1'b1;
`endif
            end
        endcase
    end

endmodule

// File: tb/tb_intersection_ctrl.sv
// ----------------------------------------------------------------------------
// tb_intersection_ctrl
//
// Self-checking bench for intersection_ctrl (default build, flash feature off).
// A reference model tracks the current phase of the light cycle and how long
// it has lasted, derived from the phase duration table and the pedestrian
// rules. Directed scenarios measure phase lengths from the lamps; a long
// randomized run compares every cycle against the model and checks safety
// invariants.
// ----------------------------------------------------------------------------
module tb_intersection_ctrl;

    localparam int CW          = 8;
    localparam int T_GREEN_NS  = 20;
    localparam int T_GREEN_EW  = 20;
    localparam int T_YELLOW    = 4;
    localparam int T_RED       = 2;
    localparam int T_WALK      = 10;
    localparam int T_MIN_GREEN = 8;
    localparam int T_FLASH     = 5;

    // Lamp vector bit positions: {ns_r, ns_y, ns_g, ew_r, ew_y, ew_g, walk}
    localparam int B_NS_G = 4;
    localparam int B_EW_G = 1;
    localparam int B_WALK = 0;

    logic clk        = 1'b0;
    logic rstn       = 1'b1;
    logic ped_req    = 1'b0;
    logic night_mode = 1'b0;
    logic ns_red, ns_yellow, ns_green;
    logic ew_red, ew_yellow, ew_green;
    logic walk, ped_pending;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    intersection_ctrl #(
        .CW(CW), .T_GREEN_NS(T_GREEN_NS), .T_GREEN_EW(T_GREEN_EW),
        .T_YELLOW(T_YELLOW), .T_RED(T_RED), .T_WALK(T_WALK),
        .T_MIN_GREEN(T_MIN_GREEN), .T_FLASH(T_FLASH)
    ) dut (
        .clk(clk), .rstn(rstn), .ped_req(ped_req), .night_mode(night_mode),
        .ns_red(ns_red), .ns_yellow(ns_yellow), .ns_green(ns_green),
        .ew_red(ew_red), .ew_yellow(ew_yellow), .ew_green(ew_green),
        .walk(walk), .ped_pending(ped_pending)
    );

    // ------------------------------------------------------------------
    // Reference model: phase + elapsed cycles in that phase (1 on entry).
    // ------------------------------------------------------------------
    typedef enum int {
        M_RED_TO_NS, M_NS_GREEN, M_NS_YELLOW,
        M_RED_TO_EW, M_EW_GREEN, M_EW_YELLOW, M_WALK
    } mphase_t;

    mphase_t m_ph;
    int      m_age;
    bit      m_pend;
    bit      m_walk_to_ew;

    function automatic int dur(input mphase_t p);
        case (p)
            M_NS_GREEN:               return T_GREEN_NS;
            M_EW_GREEN:               return T_GREEN_EW;
            M_NS_YELLOW, M_EW_YELLOW: return T_YELLOW;
            M_WALK:                   return T_WALK;
            default:                  return T_RED;
        endcase
    endfunction

    function automatic logic [6:0] exp_lamps(input mphase_t p);
        case (p)
            M_NS_GREEN:  return 7'b0011000;
            M_NS_YELLOW: return 7'b0101000;
            M_EW_GREEN:  return 7'b1000010;
            M_EW_YELLOW: return 7'b1000100;
            M_WALK:      return 7'b1001001;
            default:     return 7'b1001000;
        endcase
    endfunction

    task automatic model_reset();
        m_ph         = M_RED_TO_NS;
        m_age        = 1;
        m_pend       = 1'b0;
        m_walk_to_ew = 1'b0;
    endtask

    task automatic model_step(input bit ped);
        bit      leave;
        bit      to_walk;
        mphase_t nxt;
        leave   = (m_age == dur(m_ph));
        if ((m_ph == M_NS_GREEN || m_ph == M_EW_GREEN) && m_pend && m_age >= T_MIN_GREEN)
            leave = 1'b1;
        to_walk = 1'b0;
        nxt     = m_ph;
        if (leave) begin
            case (m_ph)
                M_NS_GREEN:  nxt = M_NS_YELLOW;
                M_NS_YELLOW: nxt = M_RED_TO_EW;
                M_EW_GREEN:  nxt = M_EW_YELLOW;
                M_EW_YELLOW: nxt = M_RED_TO_NS;
                M_WALK:      nxt = m_walk_to_ew ? M_EW_GREEN : M_NS_GREEN;
                M_RED_TO_EW: begin
                    to_walk = m_pend;
                    nxt     = m_pend ? M_WALK : M_EW_GREEN;
                    if (m_pend) m_walk_to_ew = 1'b1;
                end
                default: begin
                    to_walk = m_pend;
                    nxt     = m_pend ? M_WALK : M_NS_GREEN;
                    if (m_pend) m_walk_to_ew = 1'b0;
                end
            endcase
        end
        m_pend = to_walk ? 1'b0 : (m_pend | ped);
        if (leave) begin
            m_ph  = nxt;
            m_age = 1;
        end else begin
            m_age = m_age + 1;
        end
    endtask

    // ------------------------------------------------------------------
    // Checking and stimulus helpers
    // ------------------------------------------------------------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [6:0] lamps();
        return {ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, walk};
    endfunction

    // Called at a falling edge: assert reset asynchronously and check at once.
    task automatic do_reset(input int cyc);
        ped_req = 1'b0;
        rstn    = 1'b0;
        #1;
        model_reset();
        check("rst_lamps", lamps(), 7'b1001000);
        check("rst_pending", ped_pending, 1'b0);
        repeat (cyc) @(negedge clk);
        rstn = 1'b1;
    endtask

    // One clock: drive inputs at the falling edge, step the model, compare
    // at the next falling edge.
    task automatic tick(input bit ped);
        logic [6:0] l;
        ped_req = ped;
        if (rstn) model_step(ped);
        @(posedge clk);
        @(negedge clk);
        l = lamps();
        check("lamps", l, exp_lamps(m_ph));
        check("ped_pending", ped_pending, m_pend);
        check("never_both_go", l[6] | l[3], 1'b1);
        check("walk_all_red", !l[0] || (l[6] && l[3]), 1'b1);
        check("ns_one_lamp", $countones(l[6:4]), 1);
        check("ew_one_lamp", $countones(l[3:1]), 1);
    endtask

    // Tick until lamp bit idx equals val; n = ticks taken. Bounded.
    task automatic run_until(input int idx, input logic val, input bit ped,
                             input int budget, output int n);
        logic [6:0] l;
        n = 0;
        l = lamps();
        while (l[idx] !== val && n < budget) begin
            tick(ped);
            n++;
            l = lamps();
        end
        if (l[idx] !== val)
            check("wait_timeout", l[idx], val);
    endtask

    // Plain cycle from reset release: red 2, NS green 20, ... period 52.
    task automatic check_plain_cycle(input string tag);
        int n;
        int period;
        run_until(B_NS_G, 1'b1, 1'b0, 100, n);
        check({tag, "_red_b_len"}, n, 2);
        run_until(B_NS_G, 1'b0, 1'b0, 100, n);
        check({tag, "_ns_green_len"}, n, 20);
        period = n;
        run_until(B_EW_G, 1'b1, 1'b0, 100, n);
        check({tag, "_ns_y_red_a_len"}, n, 6);
        period += n;
        run_until(B_EW_G, 1'b0, 1'b0, 100, n);
        check({tag, "_ew_green_len"}, n, 20);
        period += n;
        run_until(B_NS_G, 1'b1, 1'b0, 100, n);
        period += n;
        check({tag, "_period"}, period, 52);
    endtask

    // ------------------------------------------------------------------
    // Test sequence
    // ------------------------------------------------------------------
    initial begin
        int n;
        @(negedge clk);

        // 1: plain cycle after reset
        do_reset(2);
        check_plain_cycle("t1");

        // 2: request at NS_G cnt=5 cuts green to 8, then walk before EW
        do_reset(2);
        run_until(B_NS_G, 1'b1, 1'b0, 100, n);
        repeat (5) tick(1'b0);
        tick(1'b1);
        check("t2_pending_set", ped_pending, 1'b1);
        run_until(B_NS_G, 1'b0, 1'b0, 100, n);
        check("t2_green_len", 6 + n, 8);
        run_until(B_WALK, 1'b1, 1'b0, 100, n);
        check("t2_to_walk", n, 6);
        check("t2_pend_cleared", ped_pending, 1'b0);
        run_until(B_WALK, 1'b0, 1'b0, 100, n);
        check("t2_walk_len", n, 10);
        check("t2_ew_after_walk", ew_green, 1'b1);

        // 3: late request (past minimum), held across WALK entry
        do_reset(2);
        run_until(B_NS_G, 1'b1, 1'b0, 100, n);
        repeat (15) tick(1'b0);
        tick(1'b1);
        run_until(B_NS_G, 1'b0, 1'b1, 100, n);
        check("t3_green_len", 16 + n, 17);
        run_until(B_WALK, 1'b1, 1'b1, 100, n);
        check("t3_to_walk", n, 6);
        check("t3_clear_wins", ped_pending, 1'b0);
        tick(1'b1);
        check("t3_reset_in_walk", ped_pending, 1'b1);
        run_until(B_WALK, 1'b0, 1'b0, 100, n);
        check("t3_walk_len", 1 + n, 10);
        check("t3_ew_after_walk", ew_green, 1'b1);
        run_until(B_EW_G, 1'b0, 1'b0, 100, n);
        check("t3_ew_green_cut", n, 8);
        run_until(B_WALK, 1'b1, 1'b0, 100, n);
        check("t3_walk_again", n, 6);

        // 4: reset mid EW green with a request outstanding
        do_reset(2);
        run_until(B_EW_G, 1'b1, 1'b0, 100, n);
        repeat (9) tick(1'b0);
        tick(1'b1);
        check("t4_pend_before", ped_pending, 1'b1);
        do_reset(3);
        check_plain_cycle("t4");

`ifndef NIGHT_FLASH_EN
        // 6: night_mode has no effect without the flash feature
        night_mode = 1'b1;
        do_reset(2);
        check_plain_cycle("t6");
        night_mode = 1'b0;
`endif

        // 5: random requests and resets against the model
        for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(0, 499) == 0)
                do_reset(int'($urandom_range(1, 3)));
`ifndef NIGHT_FLASH_EN
            night_mode = 1'($urandom_range(0, 1));
`endif
            tick($urandom_range(0, 15) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
